// File: rtl/vend_pkg.sv
// Shared state encoding and coin constants for the vend_payer slice.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PAY  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_FAIL = 3'd4
  } state_t;

  // Coin values expressed in 5-unit steps.
  localparam int FIVE_UNITS      = 1;
  localparam int TEN_UNITS       = 2;
  localparam int DEF_PRICE_UNITS = 3;

endpackage

// File: rtl/vend_wallet.sv
// Wallet of five/ten coins: two saturating counters with load, single-coin spend and five-coin bank.
module vend_wallet #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_fives,
  input  logic [CNT_W-1:0] load_tens,
  input  logic             dec_five,
  input  logic             dec_ten,
  input  logic             inc_five,
  output logic [CNT_W-1:0] fives,
  output logic [CNT_W-1:0] tens
);

  always_ff @(posedge clk) begin
    if (reset) begin
      fives <= '0;
      tens  <= '0;
    end else if (load) begin
      fives <= load_fives;
      tens  <= load_tens;
    end else begin
      // A simultaneous spend and bank of a five cancel out.
      if (dec_five && !inc_five && (fives != '0))
        fives <= fives - CNT_W'(1);
      else if (inc_five && !dec_five && (fives != '1))
        fives <= fives + CNT_W'(1);
      if (dec_ten && (tens != '0))
        tens <= tens - CNT_W'(1);
    end
  end

endmodule

// File: rtl/vend_payer.sv
// Customer-side payment controller: drives five_coin/ten_coin pulses until the price is covered.
// Build option EXACT_CHANGE_EN: refuse purchases the wallet cannot pay exactly and never overpay.
module vend_payer
  import vend_pkg::*;
#(
  parameter int PRICE_UNITS = DEF_PRICE_UNITS,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_fives,
  input  logic [CNT_W-1:0] load_tens,
  input  logic             start,
  input  logic             prefer_ten,
  input  logic             bottle,
  input  logic             change,
  output logic             five_coin,
  output logic             ten_coin,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] fives_left,
  output logic [CNT_W-1:0] tens_left,
  output logic [CNT_W-1:0] bottles
);

  localparam int PAID_W = $clog2(PRICE_UNITS + 4) + 1;
  localparam int TMR_W  = $clog2(TIMEOUT + 1) + 1;
  localparam logic [PAID_W-1:0] PRICE_P  = PAID_W'(PRICE_UNITS);
  localparam logic [PAID_W-1:0] FIVE_P   = PAID_W'(FIVE_UNITS);
  localparam logic [PAID_W-1:0] TEN_P    = PAID_W'(TEN_UNITS);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic              pref_ten_q, pref_ten_nx;
  logic [PAID_W-1:0] paid, paid_nx, coin_units;
  logic [TMR_W-1:0]  timer, timer_nx;
  logic              five_nx, ten_nx;
  logic [CNT_W-1:0]  bottles_nx;
  logic              w_load, w_dec_five, w_dec_ten, w_inc_five;
  logic [CNT_W-1:0]  fives_w, tens_w;
  logic              start_ok, rem_ge2, ten_ok_late;

  vend_wallet #(.CNT_W(CNT_W)) u_wallet (
    .clk        (clk),
    .reset      (reset),
    .load       (w_load),
    .load_fives (load_fives),
    .load_tens  (load_tens),
    .dec_five   (w_dec_five),
    .dec_ten    (w_dec_ten),
    .inc_five   (w_inc_five),
    .fives      (fives_w),
    .tens       (tens_w)
  );

  assign fives_left = fives_w;
  assign tens_left  = tens_w;

  // At least a ten's worth still owed.
  assign rem_ge2 = (paid + TEN_P) <= PRICE_P;

`ifdef EXACT_CHANGE_EN
  localparam int EW = CNT_W + PAID_W + 2;
  localparam logic [EW-1:0] HALF_E  = EW'(PRICE_UNITS / 2);
  localparam logic [EW-1:0] PRICE_E = EW'(PRICE_UNITS);
  logic [EW-1:0] tens_use, fives_need;

  // Using as many tens as fit minimises the fives needed for an exact total.
  always_comb begin
    tens_use   = (EW'(tens_w) >= HALF_E) ? HALF_E : EW'(tens_w);
    fives_need = PRICE_E - (tens_use << 1);
    start_ok   = EW'(fives_w) >= fives_need;
  end
  assign ten_ok_late = rem_ge2;
`else
  assign start_ok    = (fives_w != '0) || (tens_w != '0);
  assign ten_ok_late = 1'b1;
`endif

  always_comb begin
    state_nx    = state;
    pref_ten_nx = pref_ten_q;
    paid_nx     = paid;
    timer_nx    = timer;
    five_nx     = 1'b0;
    ten_nx      = 1'b0;
    bottles_nx  = bottles;
    coin_units  = '0;
    w_load      = 1'b0;
    w_dec_five  = 1'b0;
    w_dec_ten   = 1'b0;
    w_inc_five  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          w_load = 1'b1;
        end else if (start) begin
          if (start_ok) begin
            pref_ten_nx = prefer_ten;
            paid_nx     = '0;
            state_nx    = ST_PAY;
          end else begin
            state_nx = ST_FAIL;
          end
        end
      end
      ST_PAY: begin
        if (bottle) begin
          state_nx = ST_FAIL;
        end else begin
          if (pref_ten_q && (tens_w != '0) && rem_ge2) begin
            ten_nx     = 1'b1;
            coin_units = TEN_P;
          end else if (fives_w != '0) begin
            five_nx    = 1'b1;
            coin_units = FIVE_P;
          end else if ((tens_w != '0) && ten_ok_late) begin
            ten_nx     = 1'b1;
            coin_units = TEN_P;
          end else begin
            state_nx = ST_FAIL;
          end
          w_dec_five = five_nx;
          w_dec_ten  = ten_nx;
          paid_nx    = paid + coin_units;
          if ((five_nx || ten_nx) && (paid_nx >= PRICE_P)) begin
            state_nx = ST_WAIT;
            timer_nx = '0;
          end
        end
      end
      ST_WAIT: begin
        timer_nx   = timer + TMR_W'(1);
        w_inc_five = change;
        if (bottle) begin
          if (bottles != '1)
            bottles_nx = bottles + CNT_W'(1);
          state_nx = ST_DONE;
        end else if (timer >= TMR_LAST) begin
          state_nx = ST_FAIL;
        end
      end
      ST_DONE, ST_FAIL: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      pref_ten_q <= 1'b0;
      paid       <= '0;
      timer      <= '0;
      five_coin  <= 1'b0;
      ten_coin   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      bottles    <= '0;
    end else begin
      state      <= state_nx;
      pref_ten_q <= pref_ten_nx;
      paid       <= paid_nx;
      timer      <= timer_nx;
      five_coin  <= five_nx;
      ten_coin   <= ten_nx;
      busy       <= (state_nx == ST_PAY) || (state_nx == ST_WAIT);
      done       <= (state_nx == ST_DONE);
      fail       <= (state_nx == ST_FAIL);
      bottles    <= bottles_nx;
    end
  end

endmodule

// File: tb/tb_vend_payer.sv
// Randomised bench for vend_payer against a transaction-level model of a purchase.
module tb_vend_payer;

  localparam int CNT_W = 8;
  localparam int PRICE = 3;
  localparam int TMO   = 4;

  logic             clk = 1'b0;
  logic             reset, load, start, prefer_ten, bottle, change;
  logic [CNT_W-1:0] load_fives, load_tens;
  logic             five_coin, ten_coin, busy, done, fail;
  logic [CNT_W-1:0] fives_left, tens_left, bottles;

  int checks = 0;
  int errors = 0;
  int m_f = 0, m_t = 0, m_b = 0;

  vend_payer #(.PRICE_UNITS(PRICE), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_fives (load_fives),
    .load_tens  (load_tens),
    .start      (start),
    .prefer_ten (prefer_ten),
    .bottle     (bottle),
    .change     (change),
    .five_coin  (five_coin),
    .ten_coin   (ten_coin),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fives_left (fives_left),
    .tens_left  (tens_left),
    .bottles    (bottles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_five"}, five_coin, 0);
    check({tag, "_ten"},  ten_coin, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fail"}, fail, 0);
  endtask

  task automatic check_wallet(input string tag);
    check({tag, "_fives"},   fives_left, m_f);
    check({tag, "_tens"},    tens_left, m_t);
    check({tag, "_bottles"}, bottles, m_b);
  endtask

  task automatic do_load(input int f, input int t);
    load = 1'b1; load_fives = CNT_W'(f); load_tens = CNT_W'(t);
    tick();
    load = 1'b0;
    m_f = f; m_t = t;
    check_wallet("load");
  endtask

  // mode 0: bottle delivered d%TMO cycles into WAIT; 1: never delivered; 2: bottle during PAY.
  // chg_mode 0: no change; 1: random change every cycle; 2: change together with bottle.
  task automatic purchase(input bit pref, input int mode, input int d, input int chg_mode);
    int  coins[$];
    int  pf, pt, paid, n, ins, end_k, bottle_at, wait_lo, wait_hi, ec;
    bit  stuck, empty, exp_done;
    pf = m_f; pt = m_t; paid = 0; stuck = 0; exp_done = 0;
    bottle_at = -1; wait_lo = -1; wait_hi = -2;
    empty = (m_f == 0) && (m_t == 0);
    if (!empty) begin
      while (paid < PRICE) begin
        if (pref && pt > 0 && (PRICE - paid) >= 2) begin coins.push_back(2); pt--; paid += 2; end
        else if (pf > 0) begin coins.push_back(1); pf--; paid += 1; end
        else if (pt > 0) begin coins.push_back(2); pt--; paid += 2; end
        else begin stuck = 1; break; end
      end
    end
    n = coins.size();
    if (empty) begin
      end_k = 0; ins = 0;
    end else if (stuck) begin
      end_k = n + 1; ins = n;
    end else if (mode == 2) begin
      bottle_at = d % n; end_k = bottle_at + 1; ins = bottle_at;
    end else if (mode == 1) begin
      end_k = n + TMO; ins = n; wait_lo = n; wait_hi = n + TMO - 1;
    end else begin
      bottle_at = n + (d % TMO); end_k = bottle_at + 1; ins = n; exp_done = 1;
      wait_lo = n; wait_hi = bottle_at;
    end
    for (int i = 0; i < ins; i++) begin
      if (coins[i] == 1) m_f--; else m_t--;
    end
    if (exp_done && m_b < 255) m_b++;

    prefer_ten = pref; start = 1'b1;
    tick();
    start = 1'b0; prefer_ten = 1'($urandom_range(0, 1));
    for (int k = 0; k <= end_k; k++) begin
      ec = (k >= 1 && k <= ins) ? coins[k-1] : 0;
      check("five_coin", five_coin, ec == 1);
      check("ten_coin",  ten_coin,  ec == 2);
      check("done",      done, (k == end_k) && exp_done);
      check("fail",      fail, (k == end_k) && !exp_done);
      check("busy",      busy, (k < end_k) && !empty);
      if (k == end_k) break;
      bottle = (k == bottle_at);
      case (chg_mode)
        1:       change = 1'($urandom_range(0, 1));
        2:       change = (k == bottle_at);
        default: change = 1'b0;
      endcase
      if (change && k >= wait_lo && k <= wait_hi && m_f < 255) m_f++;
      load = ($urandom_range(0, 3) == 0);
      load_fives = CNT_W'($urandom_range(0, 200));
      load_tens  = CNT_W'($urandom_range(0, 200));
      tick();
    end
    bottle = 1'b0; change = 1'b0; load = 1'b0;
    check_wallet("end");
    start = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    check_quiet("after");
  endtask

  task automatic reset_mid_purchase();
    do_load(3, 0);
    prefer_ten = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("rst_first_coin", five_coin, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_f = 0; m_t = 0; m_b = 0;
    check_quiet("rst");
    check_wallet("rst");
    tick();
    check_quiet("rst_next");
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; prefer_ten = 1'b0;
    bottle = 1'b0; change = 1'b0; load_fives = '0; load_tens = '0;
    tick(); tick();
    check_quiet("reset");
    check_wallet("reset");
    reset = 1'b0;
    tick();

    do_load(3, 0); purchase(1'b0, 0, 1, 0);   // three fives then bottle
    do_load(1, 1); purchase(1'b1, 0, 0, 0);   // ten then five
    do_load(0, 2); purchase(1'b0, 0, 2, 2);   // overpay, change with bottle
    do_load(1, 0); purchase(1'b0, 0, 0, 0);   // runs out of coins
    do_load(3, 0); purchase(1'b0, 1, 0, 1);   // bottle never arrives
    do_load(2, 1); purchase(1'b0, 2, 1, 0);   // bottle during PAY
    do_load(0, 0); purchase(1'b1, 0, 0, 0);   // empty wallet
    reset_mid_purchase();

    for (int i = 0; i < 40; i++) begin
      if (i == 0 || $urandom_range(0, 2) != 0)
        do_load($urandom_range(0, 4), $urandom_range(0, 3));
      purchase(1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 5), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
